// File: rtl/note_game_pkg.sv
// note_game_pkg
// Shared types and constants for the note scheduler slice.
//   game_state_t     : game state enum, also the encoding seen on state_out
//   DEFAULT_WALL_COUNT : default number of wall requesters
//   REST_NOTE        : frequency code returned for grants made while draining
//   song_word()      : the melody itself, one 24-bit word {true_note, freq} per index
package note_game_pkg;

    typedef enum logic [1:0] {
        WAIT      = 2'd0,
        PLAY      = 2'd1,
        DRAIN     = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int          DEFAULT_WALL_COUNT = 3;
    localparam logic [15:0] REST_NOTE          = 16'h0000;
    localparam logic [7:0]  REST_TRUE_NOTE     = 8'h00;

    // The melody: identity byte climbs from 0x3C, frequency code climbs in
    // steps of 37 from 262. Kept as a function so the ROM folds it into
    // constant logic and every index is defined without an external image.
    function automatic logic [23:0] song_word(input int unsigned idx);
        logic [7:0]  true_note;
        logic [15:0] freq;
        true_note = 8'(32'd60 + idx);
        freq      = 16'(32'd262 + 32'd37 * idx);
        return {true_note, freq};
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom
// SONG_LEN x 24-bit synchronous-read ROM holding the melody.
// Ports:
//   clk  : clock, data is registered on its rising edge
//   addr : song index to read
//   data : {true_note[7:0], freq[15:0]} for the address seen one cycle earlier
module song_rom
    import note_game_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int ADDR_W   = 5
)(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [23:0]       data
);

    // One-cycle read latency; addresses past the end of the song read as zero.
    always_ff @(posedge clk) begin
        if (int'(addr) < SONG_LEN) begin
            data <= song_word(32'(addr));
        end else begin
            data <= '0;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler
// Round-robin arbiter that hands out song notes to wall requesters while a
// game runs, then rest notes while the game drains, then idles.
// Ports:
//   pixel_clk_in   : clock
//   rst_in         : asynchronous active-high reset
//   nf_in          : new-frame pulse, counted only while draining
//   start_in       : WAIT -> PLAY
//   restart_in     : GAME_OVER -> WAIT
//   req_in         : per-wall level request, held until granted
//   gnt_out        : one-hot grant pulse
//   note_out       : frequency code, valid with note_valid_out
//   true_note_out  : note identity byte, valid with note_valid_out
//   note_valid_out : high exactly in grant cycles
//   state_out      : current game_state_t encoding
//   final_note_out : pulses with the grant of the last song index
module note_scheduler
    import note_game_pkg::*;
#(
    parameter int WALL_COUNT   = DEFAULT_WALL_COUNT,
    parameter int SONG_LEN     = 32,
    parameter int ADDR_W       = 5,
    parameter int DRAIN_FRAMES = 120
)(
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic                  nf_in,
    input  logic                  start_in,
    input  logic                  restart_in,
    input  logic [WALL_COUNT-1:0] req_in,
    output logic [WALL_COUNT-1:0] gnt_out,
    output logic [15:0]           note_out,
    output logic [7:0]            true_note_out,
    output logic                  note_valid_out,
    output logic [1:0]            state_out,
    output logic                  final_note_out
);

    localparam int                PTR_W      = (WALL_COUNT > 1) ? $clog2(WALL_COUNT) : 1;
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(SONG_LEN - 1);

    game_state_t           state;
    game_state_t           state_next;
    logic [ADDR_W-1:0]     song_index;
    logic [PTR_W-1:0]      rr_ptr;
    logic [7:0]            frame_cnt;
    logic [23:0]           rom_data;

    logic                  p1_valid;
    logic                  p1_rest;
    logic                  p1_final;
    logic [WALL_COUNT-1:0] p1_gnt;

    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      ptr_after_win;
    logic                  arb_go;
    logic                  enter_wait;
    logic                  drain_done;

    song_rom #(
        .SONG_LEN (SONG_LEN),
        .ADDR_W   (ADDR_W)
    ) u_song_rom (
        .clk  (pixel_clk_in),
        .addr (song_index),
        .data (rom_data)
    );

    // Round-robin pick: scan walls starting at rr_ptr and take the first
    // requester; also work out where priority starts after that winner.
    always_comb begin
        int cand;
        int nxt;
        logic [PTR_W-1:0] cand_idx;
        win_found     = 1'b0;
        win_idx       = '0;
        ptr_after_win = '0;
        cand          = 0;
        nxt           = 0;
        cand_idx      = '0;
        for (int k = 0; k < WALL_COUNT; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= WALL_COUNT) begin
                cand = cand - WALL_COUNT;
            end
            cand_idx = PTR_W'(cand);
            if (!win_found && req_in[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
        nxt = int'(win_idx) + 1;
        if (nxt >= WALL_COUNT) begin
            nxt = 0;
        end
        ptr_after_win = PTR_W'(nxt);
    end

    // A new arbitration needs an active game and an empty pipeline: nothing
    // waiting on the ROM and no grant being presented this cycle.
    assign arb_go     = ((state == PLAY) || (state == DRAIN)) && !p1_valid
                        && !note_valid_out && win_found;
    assign enter_wait = (state == GAME_OVER) && restart_in;
    assign drain_done = nf_in && ((int'(frame_cnt) + 1) >= DRAIN_FRAMES);
    assign state_out  = state;

    // Game state register.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. PLAY ends on the cycle after the last note's grant,
    // which is exactly when final_note_out is high.
    always_comb begin
        state_next = state;
        case (state)
            WAIT:      if (start_in)       state_next = PLAY;
            PLAY:      if (final_note_out) state_next = DRAIN;
            DRAIN:     if (drain_done)     state_next = GAME_OVER;
            GAME_OVER: if (restart_in)     state_next = WAIT;
            default:                       state_next = WAIT;
        endcase
    end

    // Transaction pipeline: stage 1 waits for the ROM word while holding the
    // winner and the rest/final decisions made at arbitration, so a state
    // change mid-flight cannot alter what gets delivered. Stage 2 is the
    // registered output set.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            p1_valid       <= 1'b0;
            p1_rest        <= 1'b0;
            p1_final       <= 1'b0;
            p1_gnt         <= '0;
            gnt_out        <= '0;
            note_out       <= '0;
            true_note_out  <= '0;
            note_valid_out <= 1'b0;
            final_note_out <= 1'b0;
        end else begin
            p1_valid <= arb_go;
            if (arb_go) begin
                p1_gnt   <= WALL_COUNT'(1) << win_idx;
                p1_rest  <= (state == DRAIN);
                p1_final <= (state == PLAY) && (song_index == LAST_INDEX);
            end
            note_valid_out <= p1_valid;
            final_note_out <= p1_valid && p1_final;
            if (p1_valid) begin
                gnt_out       <= p1_gnt;
                note_out      <= p1_rest ? REST_NOTE : rom_data[15:0];
                true_note_out <= p1_rest ? REST_TRUE_NOTE : rom_data[23:16];
            end else begin
                gnt_out       <= '0;
                note_out      <= '0;
                true_note_out <= '0;
            end
        end
    end

    // Song position, round-robin pointer and drain frame counter. The index
    // advances at arbitration (the ROM already captured the current value)
    // and sticks at the last note; the frame counter saturates at 255.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            song_index <= '0;
            rr_ptr     <= '0;
            frame_cnt  <= '0;
        end else if (enter_wait) begin
            song_index <= '0;
            rr_ptr     <= '0;
            frame_cnt  <= '0;
        end else begin
            if (arb_go) begin
                rr_ptr <= ptr_after_win;
                if ((state == PLAY) && (song_index != LAST_INDEX)) begin
                    song_index <= song_index + ADDR_W'(1);
                end
            end
            if ((state == DRAIN) && nf_in && (frame_cnt != 8'hFF)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
